// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter_pkg
// Brief   : Shared widths and helpers for the CDB arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int RV32_DATA_WIDTH = 32;
    localparam int ROB_TAG_WIDTH   = 6;

    // Index width that stays legal for a single-source build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter_if
// Brief   : Exunit completion inputs and CDB outputs of the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int TAG_WIDTH = ROB_TAG_WIDTH
);
    localparam int SRC_W = idx_width(NUM_SRC);

    logic                                 i_flush;
    logic [NUM_SRC-1:0]                   i_exfin;
    logic [NUM_SRC*RV32_DATA_WIDTH-1:0]   i_exfin_res;
    logic [NUM_SRC*TAG_WIDTH-1:0]         i_exfin_tag;
    logic [NUM_SRC-1:0]                   o_inaccessable;
    logic                                 o_cdb_vld;
    logic [RV32_DATA_WIDTH-1:0]           o_cdb_res;
    logic [TAG_WIDTH-1:0]                 o_cdb_tag;
    logic [SRC_W-1:0]                     o_cdb_src;
    logic                                 o_ovf;

    modport master (
        output i_flush, i_exfin, i_exfin_res, i_exfin_tag,
        input  o_inaccessable, o_cdb_vld, o_cdb_res, o_cdb_tag, o_cdb_src, o_ovf
    );

    modport slave (
        input  i_flush, i_exfin, i_exfin_res, i_exfin_tag,
        output o_inaccessable, o_cdb_vld, o_cdb_res, o_cdb_tag, o_cdb_src, o_ovf
    );

endinterface
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module  : cdb_src_fifo
// Brief   : Per-source synchronous FIFO with flush; push allowed when full
//           only together with a pop.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_src_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_flush,
    input  wire logic                     i_push,
    input  wire logic                     i_pop,
    input  wire logic [WIDTH-1:0]         i_din,
    output logic      [WIDTH-1:0]         o_head,
    output logic      [$clog2(DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Round-robin CDB arbiter over per-source result FIFOs with a
//           registered one-beat-per-cycle output. Define CDB_BYPASS_EN to let
//           an empty source's fresh result go straight to the CDB.
// Revision: 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = ROB_TAG_WIDTH
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cdb_arbiter_if.slave  bus
);
    localparam int SRC_W = idx_width(NUM_SRC);
    localparam int SW1   = SRC_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = RV32_DATA_WIDTH + TAG_WIDTH;

    logic [ENT_W-1:0]           w_in_ent [NUM_SRC];
    logic [ENT_W-1:0]           w_head   [NUM_SRC];
    logic [CNT_W-1:0]           w_count  [NUM_SRC];
    logic [NUM_SRC-1:0]         w_full;
    logic [NUM_SRC-1:0]         w_empty;
    logic [NUM_SRC-1:0]         w_cand;
    logic [NUM_SRC-1:0]         w_sel;
    logic [NUM_SRC-1:0]         w_pop;
    logic [NUM_SRC-1:0]         w_byp;
    logic [NUM_SRC-1:0]         w_push;
    logic                       w_gnt_vld;
    logic [SRC_W-1:0]           w_gnt_idx;
    logic [ENT_W-1:0]           w_gnt_ent;
    logic                       w_ovf_evt;

    logic [SRC_W-1:0]           r_rr;
    logic                       r_vld;
    logic [RV32_DATA_WIDTH-1:0] r_res;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic [SRC_W-1:0]           r_src;
    logic                       r_ovf;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_in_ent[gi] = {bus.i_exfin_res[gi*RV32_DATA_WIDTH +: RV32_DATA_WIDTH],
                                   bus.i_exfin_tag[gi*TAG_WIDTH +: TAG_WIDTH]};
`ifdef CDB_BYPASS_EN
            assign w_cand[gi] = !w_empty[gi] || bus.i_exfin[gi];
`else
            assign w_cand[gi] = !w_empty[gi];
`endif
            assign w_sel[gi]  = w_gnt_vld && (w_gnt_idx == SRC_W'(gi));
            assign w_pop[gi]  = w_sel[gi] && !w_empty[gi];
            // A granted empty source can only be a bypass winner; it skips the FIFO.
            assign w_byp[gi]  = w_sel[gi] && w_empty[gi];
            assign w_push[gi] = bus.i_exfin[gi] && !w_byp[gi];
            assign bus.o_inaccessable[gi] = (w_count[gi] >= CNT_W'(FIFO_DEPTH-1));

            cdb_src_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (ENT_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_flush (bus.i_flush),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_din   (w_in_ent[gi]),
                .o_head  (w_head[gi]),
                .o_count (w_count[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi])
            );
        end
    endgenerate

    // First candidate at or after the RR pointer, wrapping at NUM_SRC.
    always_comb begin
        logic [SW1-1:0] try_idx;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        try_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            try_idx = {1'b0, r_rr} + SW1'(k);
            if (try_idx >= SW1'(NUM_SRC)) try_idx = try_idx - SW1'(NUM_SRC);
            if (!w_gnt_vld && w_cand[try_idx[SRC_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = try_idx[SRC_W-1:0];
            end
        end
    end

    assign w_gnt_ent = w_empty[w_gnt_idx] ? w_in_ent[w_gnt_idx] : w_head[w_gnt_idx];
    assign w_ovf_evt = (|(bus.i_exfin & w_full & ~w_pop)) && !bus.i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr  <= '0;
            r_vld <= 1'b0;
            r_res <= '0;
            r_tag <= '0;
            r_src <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_ovf_evt;
            if (bus.i_flush) begin
                r_vld <= 1'b0;
            end else if (w_gnt_vld) begin
                r_vld          <= 1'b1;
                {r_res, r_tag} <= w_gnt_ent;
                r_src          <= w_gnt_idx;
                r_rr           <= (w_gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + 1'b1;
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

    assign bus.o_cdb_vld = r_vld;
    assign bus.o_cdb_res = r_res;
    assign bus.o_cdb_tag = r_tag;
    assign bus.o_cdb_src = r_src;
    assign bus.o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Self-checking bench for cdb_arbiter against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int TW = 6;
    localparam int DW = RV32_DATA_WIDTH;
    localparam int EW = DW + TW;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 1;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_SRC(N), .TAG_WIDTH(TW)) bus ();

    cdb_arbiter #(
        .NUM_SRC    (N),
        .FIFO_DEPTH (D),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference: one queue per source, pointer as an integer.
    logic [EW-1:0] m_q [N][$];
    int            m_rr  = 0;
    logic          m_vld = 1'b0;
    logic [DW-1:0] m_res = '0;
    logic [TW-1:0] m_tag = '0;
    logic [1:0]    m_src = '0;
    logic          m_ovf = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic model_step();
        logic [EW-1:0] e;
        int g;
        bit byp;
        if (rst) begin
            for (int i = 0; i < N; i++) m_q[i].delete();
            m_rr = 0; m_vld = 1'b0; m_res = '0; m_tag = '0; m_src = '0; m_ovf = 1'b0;
        end else if (bus.i_flush) begin
            for (int i = 0; i < N; i++) m_q[i].delete();
            m_vld = 1'b0;
        end else begin
            g = -1;
            byp = 1'b0;
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_rr + k) % N;
                if (g < 0 && (m_q[s].size() > 0 || (BYP && bus.i_exfin[s]))) g = s;
            end
            if (g >= 0) begin
                if (m_q[g].size() > 0) e = m_q[g].pop_front();
                else begin
                    e = {bus.i_exfin_res[g*DW +: DW], bus.i_exfin_tag[g*TW +: TW]};
                    byp = 1'b1;
                end
                m_vld = 1'b1;
                m_res = e[EW-1:TW];
                m_tag = e[TW-1:0];
                m_src = 2'(g);
                m_rr  = (g + 1) % N;
            end else begin
                m_vld = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.i_exfin[i] && !(byp && i == g)) begin
                    if (m_q[i].size() < D)
                        m_q[i].push_back({bus.i_exfin_res[i*DW +: DW], bus.i_exfin_tag[i*TW +: TW]});
                    else
                        m_ovf = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [45:0] dut_snap();
        return {bus.o_cdb_vld, bus.o_cdb_res, bus.o_cdb_tag, bus.o_cdb_src, bus.o_ovf, bus.o_inaccessable};
    endfunction

    function automatic logic [45:0] mdl_snap();
        logic [N-1:0] ia;
        for (int i = 0; i < N; i++) ia[i] = (m_q[i].size() >= D - 1);
        return {m_vld, m_res, m_tag, m_src, m_ovf, ia};
    endfunction

    task automatic set_in(input logic [N-1:0] ex, input logic fl);
        bus.i_exfin = ex;
        bus.i_flush = fl;
        for (int i = 0; i < N; i++) begin
            bus.i_exfin_res[i*DW +: DW] = $urandom;
            bus.i_exfin_tag[i*TW +: TW] = TW'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in('0, 1'b0);
        cycle();
        checks++;
        if (dut_snap() !== 46'd0) begin
            errors++; $display("FAIL reset_state got %h exp %h", dut_snap(), 46'd0);
        end
        cycle();
        checks++;
        if (dut_snap() !== mdl_snap()) begin
            errors++; $display("FAIL reset_model got %h exp %h", dut_snap(), mdl_snap());
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_in(4'b0100, 1'b0);
        bus.i_exfin_res[2*DW +: DW] = 32'hDEADBEEF;
        bus.i_exfin_tag[2*TW +: TW] = 6'd5;
        for (int c = 1; c <= 3; c++) begin
            cycle();
            if (c == 1) set_in('0, 1'b0);
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                errors++; $display("FAIL single_model c=%0d got %h exp %h", c, dut_snap(), mdl_snap());
            end
            checks++;
            if (bus.o_cdb_vld !== (c == LAT)) begin
                errors++; $display("FAIL single_vld c=%0d got %b exp %b", c, bus.o_cdb_vld, (c == LAT));
            end
            if (c == LAT) begin
                checks++;
                if ({bus.o_cdb_res, bus.o_cdb_tag, bus.o_cdb_src} !== {32'hDEADBEEF, 6'd5, 2'd2}) begin
                    errors++; $display("FAIL single_beat got %h/%0d/%0d exp deadbeef/5/2",
                                       bus.o_cdb_res, bus.o_cdb_tag, bus.o_cdb_src);
                end
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        set_in('1, 1'b0);
        for (int i = 0; i < N; i++) begin
            bus.i_exfin_res[i*DW +: DW] = 32'h1000 + i;
            bus.i_exfin_tag[i*TW +: TW] = TW'(i + 8);
        end
        for (int c = 1; c <= LAT + 5; c++) begin
            bit exp_vld;
            cycle();
            if (c == 1) set_in('0, 1'b0);
            exp_vld = (c >= LAT) && (c <= LAT + 3);
            checks++;
            if (bus.o_cdb_vld !== exp_vld) begin
                errors++; $display("FAIL contend_vld c=%0d got %b exp %b", c, bus.o_cdb_vld, exp_vld);
            end
            if (exp_vld) begin
                checks++;
                if ({bus.o_cdb_src, bus.o_cdb_res, bus.o_cdb_tag} !== {2'(c - LAT), 32'h1000 + (c - LAT), 6'(c - LAT + 8)}) begin
                    errors++; $display("FAIL contend_beat c=%0d got src %0d res %h tag %0d exp src %0d",
                                       c, bus.o_cdb_src, bus.o_cdb_res, bus.o_cdb_tag, c - LAT);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] iss;
        bit seen;
        int prev;
        do_reset();
        iss  = 2'b11;
        seen = 1'b0;
        prev = -1;
        for (int c = 0; c < 30; c++) begin
            set_in({2'b00, iss}, 1'b0);
            iss = ~bus.o_inaccessable[1:0];
            cycle();
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                errors++; $display("FAIL fair_model c=%0d got %h exp %h", c, dut_snap(), mdl_snap());
            end
            if (bus.o_cdb_vld === 1'b1) begin
                checks++;
                if (int'(bus.o_cdb_src) > 1 || int'(bus.o_cdb_src) == prev) begin
                    errors++; $display("FAIL fair_alternate c=%0d got src %0d prev %0d", c, bus.o_cdb_src, prev);
                end
                prev = int'(bus.o_cdb_src);
            end
            if (bus.o_inaccessable[0] === 1'b1) seen = 1'b1;
        end
        set_in('0, 1'b0);
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL fair_inacc_rise got %b exp 1", seen);
        end
        checks++;
        if (bus.o_ovf !== 1'b0) begin
            errors++; $display("FAIL fair_no_ovf got %b exp 0", bus.o_ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            set_in((c < 8) ? '1 : '0, 1'b0);
            cycle();
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                errors++; $display("FAIL ovf_model c=%0d got %h exp %h", c, dut_snap(), mdl_snap());
            end
        end
        checks++;
        if ({bus.o_ovf, bus.o_cdb_vld} !== 2'b10) begin
            errors++; $display("FAIL ovf_sticky got ovf %b vld %b exp ovf 1 vld 0", bus.o_ovf, bus.o_cdb_vld);
        end
        do_reset();
        checks++;
        if (bus.o_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_rst_clear got %b exp 0", bus.o_ovf);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            set_in('1, 1'b0);
            cycle();
        end
        set_in('1, 1'b1);
        cycle();
        checks++;
        if ({bus.o_cdb_vld, bus.o_inaccessable} !== 5'b0) begin
            errors++; $display("FAIL flush_state got vld %b inacc %b exp 0/0", bus.o_cdb_vld, bus.o_inaccessable);
        end
        checks++;
        if (dut_snap() !== mdl_snap()) begin
            errors++; $display("FAIL flush_model got %h exp %h", dut_snap(), mdl_snap());
        end
        set_in('0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            checks++;
            if (bus.o_cdb_vld !== 1'b0) begin
                errors++; $display("FAIL flush_late_beat c=%0d got %b exp 0", c, bus.o_cdb_vld);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in('1, 1'b0);
            cycle();
        end
        rst = 1'b1;
        set_in('1, 1'b0);
        cycle();
        checks++;
        if (dut_snap() !== 46'd0) begin
            errors++; $display("FAIL rstmid_state got %h exp %h", dut_snap(), 46'd0);
        end
        rst = 1'b0;
        set_in('0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            cycle();
            checks++;
            if (bus.o_cdb_vld !== 1'b0) begin
                errors++; $display("FAIL rstmid_late_beat c=%0d got %b exp 0", c, bus.o_cdb_vld);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            set_in(N'($urandom), ($urandom_range(0, 63) == 0));
            cycle();
            checks++;
            if (dut_snap() !== mdl_snap()) begin
                errors++; $display("FAIL random_model c=%0d got %h exp %h", c, dut_snap(), mdl_snap());
            end
        end
        rst = 1'b0;
        set_in('0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        set_in('0, 1'b0);
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
